// File: rtl/tb_run_ctrl.sv
// Run controller for a simulation harness: DUT reset, hang watchdog, drain, dump enable.
// Ports: clk, rst (async active-low), commit_valid/commit_halt/error in;
//   dut_rst_n, dump_on, done, pass, fail, timeout, cycle_count, commit_count out.
// Macro TB_DUMP_WINDOW_EN limits dump_on to [DUMP_START, DUMP_START+DUMP_LEN).
module tb_run_ctrl #(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned DRAIN_CYCLES   = 8,
  parameter logic [63:0] DUMP_START     = 64'd0,
  parameter logic [63:0] DUMP_LEN       = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic        commit_halt,
  input  logic        error,
  output logic        dut_rst_n,
  output logic        dump_on,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [63:0] cycle_count,
  output logic [63:0] commit_count
);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST =
    8'(RESET_CYCLES - 1);
  // A zero-length drain still spends one cycle in DRAIN.
  localparam logic [7:0] DRAIN_LAST =
    (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);
  localparam logic [31:0] TMO_LAST =
    32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_hold;
  logic [7:0]  r_drain;
  logic [31:0] r_idle;

  state_t      w_state_nxt;
  logic        w_halt;
  logic        w_idle_hit;
  logic        w_act_nxt;
  logic        w_dump_nxt;
  logic [63:0] w_cyc_inc;
  logic [63:0] w_cmt_inc;
  logic [63:0] w_cyc_nxt;

  assign w_halt = commit_valid & commit_halt;
  // r_idle counts idle cycles already seen; this one would reach the limit.
  assign w_idle_hit = !commit_valid &&
                      (r_idle >= TMO_LAST);

  assign w_cyc_inc = (&cycle_count) ? cycle_count
                   : cycle_count + 64'd1;
  assign w_cmt_inc = (&commit_count) ? commit_count
                   : commit_count + 64'd1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HOLD:
        if (r_hold == HOLD_LAST)
          w_state_nxt = RUN;
      RUN:
        if (error || w_halt || w_idle_hit)
          w_state_nxt = DRAIN;
      DRAIN:
        if (r_drain == DRAIN_LAST)
          w_state_nxt = DONE;
      DONE:
        w_state_nxt = DONE;
      default:
        w_state_nxt = HOLD;
    endcase
  end

  always_comb begin
    w_cyc_nxt = cycle_count;
    if (r_state == RUN || r_state == DRAIN)
      w_cyc_nxt = w_cyc_inc;
  end

  // dump_on is computed from next state/count so the
  // registered value lines up with the state it describes.
  assign w_act_nxt = (w_state_nxt == RUN) ||
                     (w_state_nxt == DRAIN);

`ifdef TB_DUMP_WINDOW_EN
  logic w_win;
  assign w_win = (w_cyc_nxt >= DUMP_START) &&
                 ((DUMP_LEN == 64'd0) ||
                  (w_cyc_nxt < DUMP_START + DUMP_LEN));
  assign w_dump_nxt = w_act_nxt && w_win;
`else
  assign w_dump_nxt = w_act_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= HOLD;
      r_hold       <= 8'd0;
      r_drain      <= 8'd0;
      r_idle       <= 32'd0;
      dut_rst_n    <= 1'b0;
      dump_on      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= 64'd0;
      commit_count <= 64'd0;
    end else begin
      r_state     <= w_state_nxt;
      cycle_count <= w_cyc_nxt;
      dump_on     <= w_dump_nxt;
      unique case (r_state)
        HOLD: begin
          r_hold <= r_hold + 8'd1;
          if (r_hold == HOLD_LAST)
            dut_rst_n <= 1'b1;
        end
        RUN: begin
          if (commit_valid) begin
            commit_count <= w_cmt_inc;
            r_idle       <= 32'd0;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
          if (error) begin
            fail <= 1'b1;
            pass <= 1'b0;
          end else if (w_halt) begin
            pass <= 1'b1;
          end else if (w_idle_hit) begin
            fail    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DRAIN: begin
          r_drain <= r_drain + 8'd1;
          if (error) begin
            fail <= 1'b1;
            pass <= 1'b0;
          end
          if (r_drain == DRAIN_LAST)
            done <= 1'b1;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Bench for tb_run_ctrl: scenario table, cycle model
// with scoreboard queues, two parameter sets in parallel.
module tb_tb_run_ctrl;

  localparam int RCY = 4;
  localparam int A_TMO = 10000;
  localparam int A_DRN = 8;
  localparam int B_TMO = 50;
  localparam int B_DRN = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cv  = 1'b0;
  logic ch  = 1'b0;
  logic er  = 1'b0;

  logic        a_rn, a_dump, a_done;
  logic        a_pass, a_fail, a_to;
  logic [63:0] a_cyc, a_cmt;
  logic        b_rn, b_dump, b_done;
  logic        b_pass, b_fail, b_to;
  logic [63:0] b_cyc, b_cmt;

  always #5 clk = ~clk;

  tb_run_ctrl #(
    .RESET_CYCLES(RCY),
    .TIMEOUT_CYCLES(A_TMO),
    .DRAIN_CYCLES(A_DRN),
    .DUMP_START(64'd10),
    .DUMP_LEN(64'd5)
  ) u_a (
    .clk(clk), .rst(rst),
    .commit_valid(cv), .commit_halt(ch),
    .error(er),
    .dut_rst_n(a_rn), .dump_on(a_dump),
    .done(a_done), .pass(a_pass),
    .fail(a_fail), .timeout(a_to),
    .cycle_count(a_cyc), .commit_count(a_cmt)
  );

  tb_run_ctrl #(
    .RESET_CYCLES(RCY),
    .TIMEOUT_CYCLES(B_TMO),
    .DRAIN_CYCLES(B_DRN),
    .DUMP_START(64'd0),
    .DUMP_LEN(64'd0)
  ) u_b (
    .clk(clk), .rst(rst),
    .commit_valid(cv), .commit_halt(ch),
    .error(er),
    .dut_rst_n(b_rn), .dump_on(b_dump),
    .done(b_done), .pass(b_pass),
    .fail(b_fail), .timeout(b_to),
    .cycle_count(b_cyc), .commit_count(b_cmt)
  );

  typedef struct {
    logic        rn, dump, done;
    logic        pass, fail, to;
    logic [63:0] cyc, cmt;
  } obs_t;

  typedef struct {
    int   st, hc, dc, idle;
    obs_t o;
  } mdl_t;

  typedef struct {
    string name;
    int ncyc, cv_last, halt_at, err_at;
    int rst_at, rst_len, rn_rise;
    int a_pass, a_fail, a_to, a_done;
    int a_cmt, a_cyc, a_done_c;
    int b_pass, b_fail, b_to, b_done;
    int b_cmt, b_cyc, b_done_c;
  } scn_t;

  int checks = 0;
  int failures = 0;
  obs_t qa[$];
  obs_t qb[$];

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.hc = 0; m.dc = 0; m.idle = 0;
    m.o.rn = 0; m.o.dump = 0; m.o.done = 0;
    m.o.pass = 0; m.o.fail = 0; m.o.to = 0;
    m.o.cyc = 0; m.o.cmt = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(
    mdl_t m, logic r, logic v, logic h, logic e,
    int tmo, int drn, logic [63:0] ds,
    logic [63:0] dl);
    mdl_t n;
    logic act, win;
    if (!r) return mreset();
    n = m;
    case (m.st)
      0: begin
        n.hc = m.hc + 1;
        if (n.hc == RCY) begin
          n.st = 1;
          n.o.rn = 1;
        end
      end
      1: begin
        n.o.cyc = m.o.cyc + 1;
        if (v) begin
          n.o.cmt = m.o.cmt + 1;
          n.idle = 0;
        end else begin
          n.idle = m.idle + 1;
        end
        if (e) begin
          n.o.fail = 1; n.o.pass = 0; n.st = 2;
        end else if (v && h) begin
          n.o.pass = 1; n.st = 2;
        end else if (n.idle >= tmo) begin
          n.o.fail = 1; n.o.to = 1; n.st = 2;
        end
      end
      2: begin
        n.o.cyc = m.o.cyc + 1;
        if (e) begin
          n.o.fail = 1; n.o.pass = 0;
        end
        n.dc = m.dc + 1;
        if (n.dc >= drn) begin
          n.st = 3; n.o.done = 1;
        end
      end
      default: ;
    endcase
    act = (n.st == 1) || (n.st == 2);
    win = (n.o.cyc >= ds) &&
          ((dl == 0) || (n.o.cyc < ds + dl));
`ifndef TB_DUMP_WINDOW_EN
    win = 1'b1;
`endif
    n.o.dump = act && win;
    return n;
  endfunction

  task automatic cmp(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic cmp_obs(string t, obs_t a, obs_t e);
    cmp({t, ".rn"},   64'(a.rn),   64'(e.rn));
    cmp({t, ".dump"}, 64'(a.dump), 64'(e.dump));
    cmp({t, ".done"}, 64'(a.done), 64'(e.done));
    cmp({t, ".pass"}, 64'(a.pass), 64'(e.pass));
    cmp({t, ".fail"}, 64'(a.fail), 64'(e.fail));
    cmp({t, ".to"},   64'(a.to),   64'(e.to));
    cmp({t, ".cyc"},  a.cyc, e.cyc);
    cmp({t, ".cmt"},  a.cmt, e.cmt);
  endtask

  function automatic obs_t get_a();
    obs_t o;
    o.rn = a_rn; o.dump = a_dump; o.done = a_done;
    o.pass = a_pass; o.fail = a_fail; o.to = a_to;
    o.cyc = a_cyc; o.cmt = a_cmt;
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o.rn = b_rn; o.dump = b_dump; o.done = b_done;
    o.pass = b_pass; o.fail = b_fail; o.to = b_to;
    o.cyc = b_cyc; o.cmt = b_cmt;
    return o;
  endfunction

  initial begin
    scn_t tbl[5];
    mdl_t ma, mb;
    obs_t zero, ea, eb;
    int rn_rise, a_dc, b_dc;
    int d_n;
    logic [63:0] d_lo, d_hi;
    logic prev_rn;
    string tg;

    tbl[0] = '{"nominal", 40, 1000, 23, -1, -1, 0, 3,
               1, 0, 0, 1, 20, 28, 31,
               1, 0, 0, 1, 20, 21, 24};
    tbl[1] = '{"timeout", 70, 6, -1, -1, -1, 0, 3,
               0, 0, 0, 0, 3, 66, -1,
               0, 1, 1, 1, 3, 54, 57};
    tbl[2] = '{"err_halt", 30, 1000, 9, 9, -1, 0, 3,
               0, 1, 0, 1, 6, 14, 17,
               0, 1, 0, 1, 6, 7, 10};
    tbl[3] = '{"err_drain", 30, 1000, 9, 12, -1, 0, 3,
               0, 1, 0, 1, 6, 14, 17,
               1, 0, 0, 1, 6, 7, 10};
    tbl[4] = '{"mid_rst", 50, 1000, -1, -1, 30, 2, 35,
               0, 0, 0, 0, 14, 14, -1,
               0, 0, 0, 0, 14, 14, -1};

    zero = mreset().o;

    for (int s = 0; s < 5; s++) begin
      rst = 1'b0; cv = 0; ch = 0; er = 0;
      #1;
      cmp_obs({tbl[s].name, " rst A"}, get_a(), zero);
      cmp_obs({tbl[s].name, " rst B"}, get_b(), zero);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      ma = mreset(); mb = mreset();
      qa.delete(); qb.delete();
      rn_rise = -1; a_dc = -1; b_dc = -1;
      prev_rn = 1'b0;
      d_n = 0; d_lo = '1; d_hi = 0;

      for (int c = 0; c < tbl[s].ncyc; c++) begin
        if (c == tbl[s].rst_at) begin
          rst = 1'b0;
          #1;
          tg = $sformatf("%s async c%0d", tbl[s].name, c);
          cmp_obs({tg, " A"}, get_a(), zero);
          cmp_obs({tg, " B"}, get_b(), zero);
        end
        if (c == tbl[s].rst_at + tbl[s].rst_len)
          rst = 1'b1;
        cv = (c <= tbl[s].cv_last);
        ch = (c == tbl[s].halt_at);
        er = (c == tbl[s].err_at);
        ma = mstep(ma, rst, cv, ch, er,
                   A_TMO, A_DRN, 64'd10, 64'd5);
        mb = mstep(mb, rst, cv, ch, er,
                   B_TMO, B_DRN, 64'd0, 64'd0);
        qa.push_back(ma.o);
        qb.push_back(mb.o);
        @(posedge clk);
        #1;
        tg = $sformatf("%s c%0d", tbl[s].name, c);
        if (qa.size() == 0 || qb.size() == 0) begin
          cmp({tg, " sb_empty"}, 64'd1, 64'd0);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          cmp_obs({tg, " A"}, get_a(), ea);
          cmp_obs({tg, " B"}, get_b(), eb);
        end
        if (a_rn && !prev_rn) rn_rise = c;
        prev_rn = a_rn;
        if (a_done && a_dc < 0) a_dc = c;
        if (b_done && b_dc < 0) b_dc = c;
        if (a_dump) begin
          d_n++;
          if (a_cyc < d_lo) d_lo = a_cyc;
          if (a_cyc > d_hi) d_hi = a_cyc;
        end
      end

      tg = tbl[s].name;
      cmp({tg, " rn_rise"}, 64'(rn_rise),
          64'(tbl[s].rn_rise));
      cmp({tg, " A.pass"}, 64'(a_pass), 64'(tbl[s].a_pass));
      cmp({tg, " A.fail"}, 64'(a_fail), 64'(tbl[s].a_fail));
      cmp({tg, " A.to"},   64'(a_to),   64'(tbl[s].a_to));
      cmp({tg, " A.done"}, 64'(a_done), 64'(tbl[s].a_done));
      cmp({tg, " A.cmt"},  a_cmt, 64'(tbl[s].a_cmt));
      cmp({tg, " A.cyc"},  a_cyc, 64'(tbl[s].a_cyc));
      cmp({tg, " A.done_c"}, 64'(a_dc),
          64'(tbl[s].a_done_c));
      cmp({tg, " B.pass"}, 64'(b_pass), 64'(tbl[s].b_pass));
      cmp({tg, " B.fail"}, 64'(b_fail), 64'(tbl[s].b_fail));
      cmp({tg, " B.to"},   64'(b_to),   64'(tbl[s].b_to));
      cmp({tg, " B.done"}, 64'(b_done), 64'(tbl[s].b_done));
      cmp({tg, " B.cmt"},  b_cmt, 64'(tbl[s].b_cmt));
      cmp({tg, " B.cyc"},  b_cyc, 64'(tbl[s].b_cyc));
      cmp({tg, " B.done_c"}, 64'(b_dc),
          64'(tbl[s].b_done_c));

      if (s == 0) begin
`ifdef TB_DUMP_WINDOW_EN
        cmp("dump_n",  64'(d_n), 64'd5);
        cmp("dump_lo", d_lo, 64'd10);
        cmp("dump_hi", d_hi, 64'd14);
`else
        cmp("dump_n",  64'(d_n), 64'd28);
        cmp("dump_lo", d_lo, 64'd0);
        cmp("dump_hi", d_hi, 64'd27);
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
